riscv_divider: RTL and testbench

Iterative 32-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside `riscv_multiplier` and takes the same registered ID-stage operands. It freezes the pipeline through `ex_stall_div_w` until the result is ready. Its 32-bit result is muxed with the multiplier result ahead of writeback.

---
 rtl/riscv_divider_pkg.sv | 20 ++
 rtl/riscv_div_step.sv | 25 ++
 rtl/riscv_divider.sv | 132 +++++++++++++
 tb/tb_riscv_divider.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_divider_pkg.sv
// Shared constants and types for the RV32M iterative divider.
package riscv_divider_pkg;

    localparam logic [3:0] ALU_DIV  = 4'hC;
    localparam logic [3:0] ALU_DIVU = 4'hD;
    localparam logic [3:0] ALU_REM  = 4'hE;
    localparam logic [3:0] ALU_REMU = 4'hF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division step: shift {rem, dvd} left and conditionally subtract.
// The partial remainder is always below the divisor on entry, so the shifted
// value is below twice the divisor and a 33-bit difference keeps a valid sign bit.
module riscv_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] dvd,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] dvd_next
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // Trial subtraction; the quotient bit enters at the bottom of the dividend.
    always_comb begin
        shifted  = {rem, dvd[31]};
        diff     = shifted - {1'b0, divisor};
        fits     = ~diff[32];
        rem_next = fits ? diff[31:0] : shifted[31:0];
        dvd_next = {dvd[30:0], fits};
    end

endmodule

// File: rtl/riscv_divider.sv
// Iterative 32-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are held stable by the pipeline while the stall output is high.
import riscv_divider_pkg::*;

module riscv_divider (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        id_valid_r,
    input  logic [3:0]  id_alu_op_r,
    input  logic [31:0] id_ra_value_r,
    input  logic [31:0] id_rb_value_r,
    input  logic        ex_flush_i,
    output logic [31:0] div_res_w,
    output logic        div_valid_w,
    output logic        ex_stall_div_w
);

    div_state_t  state;
    logic [31:0] rem;
    logic [31:0] dvd;
    logic [31:0] divisor;
    logic [4:0]  count;
    logic        q_neg;
    logic        r_neg;
    logic        is_rem;
    logic [31:0] result;
    logic        valid;

    logic        div_op;
    logic        signed_op;
    logic        rem_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        overflow;
    logic [31:0] step_rem;
    logic [31:0] step_dvd;
    logic [31:0] quot_final;
    logic [31:0] rem_final;

    // Operation decode, operand magnitudes and sign-corrected final results.
    always_comb begin
        div_op     = id_valid_r && is_div_op(id_alu_op_r);
        signed_op  = (id_alu_op_r == ALU_DIV) || (id_alu_op_r == ALU_REM);
        rem_op     = (id_alu_op_r == ALU_REM) || (id_alu_op_r == ALU_REMU);
        a_neg      = signed_op && id_ra_value_r[31];
        b_neg      = signed_op && id_rb_value_r[31];
        abs_a      = a_neg ? (~id_ra_value_r + 32'd1) : id_ra_value_r;
        abs_b      = b_neg ? (~id_rb_value_r + 32'd1) : id_rb_value_r;
        overflow   = signed_op && (id_ra_value_r == 32'h8000_0000) &&
                     (id_rb_value_r == 32'hFFFF_FFFF);
        quot_final = q_neg ? (~step_dvd + 32'd1) : step_dvd;
        rem_final  = r_neg ? (~step_rem + 32'd1) : step_rem;
    end

    riscv_div_step u_step (
        .rem      (rem),
        .dvd      (dvd),
        .divisor  (divisor),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    // Control FSM and datapath registers; flush squashes any op in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state   <= DIV_IDLE;
            rem     <= 32'd0;
            dvd     <= 32'd0;
            divisor <= 32'd0;
            count   <= 5'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_rem  <= 1'b0;
            result  <= 32'd0;
            valid   <= 1'b0;
        end else if (ex_flush_i) begin
            state <= DIV_IDLE;
            valid <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    valid <= 1'b0;
                    if (div_op) begin
                        if (id_rb_value_r == 32'd0) begin
                            result <= rem_op ? id_ra_value_r : 32'hFFFF_FFFF;
                            valid  <= 1'b1;
                            state  <= DIV_DONE;
                        end else if (overflow) begin
                            result <= rem_op ? 32'd0 : 32'h8000_0000;
                            valid  <= 1'b1;
                            state  <= DIV_DONE;
                        end else begin
                            rem     <= 32'd0;
                            dvd     <= abs_a;
                            divisor <= abs_b;
                            count   <= 5'd0;
                            q_neg   <= a_neg ^ b_neg;
                            r_neg   <= a_neg;
                            is_rem  <= rem_op;
                            state   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem   <= step_rem;
                    dvd   <= step_dvd;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= is_rem ? rem_final : quot_final;
                        valid  <= 1'b1;
                        state  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    valid <= 1'b0;
                    state <= DIV_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign div_res_w      = result;
    assign div_valid_w    = valid;
    assign ex_stall_div_w = reset_i && div_op && (state != DIV_DONE);

endmodule

// File: tb/tb_riscv_divider.sv
// Directed, table-driven testbench for riscv_divider.
module tb_riscv_divider;

    localparam logic [3:0] OP_DIV  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REM  = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;
    localparam int NUM_VECS = 19;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        id_valid_r;
    logic [3:0]  id_alu_op_r;
    logic [31:0] id_ra_value_r;
    logic [31:0] id_rb_value_r;
    logic        ex_flush_i;
    logic [31:0] div_res_w;
    logic        div_valid_w;
    logic        ex_stall_div_w;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NUM_VECS];

    riscv_divider dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .id_valid_r     (id_valid_r),
        .id_alu_op_r    (id_alu_op_r),
        .id_ra_value_r  (id_ra_value_r),
        .id_rb_value_r  (id_rb_value_r),
        .ex_flush_i     (ex_flush_i),
        .div_res_w      (div_res_w),
        .div_valid_w    (div_valid_w),
        .ex_stall_div_w (ex_stall_div_w)
    );

    // Free-running core clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Presents one op starting right after a rising edge and waits for its
    // valid pulse; on return the op has been retired and the next op can be
    // presented immediately (back-to-back).
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output int lat, output int stall_cycles,
                                 output logic stall_at_done, output logic seen);
        id_valid_r    = 1'b1;
        id_alu_op_r   = op;
        id_ra_value_r = a;
        id_rb_value_r = b;
        res           = 32'd0;
        lat           = -1;
        stall_cycles  = 0;
        stall_at_done = 1'b1;
        seen          = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            if (div_valid_w) begin
                res           = div_res_w;
                lat           = c;
                stall_at_done = ex_stall_div_w;
                seen          = 1'b1;
                break;
            end
            if (ex_stall_div_w) stall_cycles++;
        end
        @(posedge clk_i);
        #1;
        id_valid_r = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected, input int latency);
        logic [31:0] res;
        int          lat;
        int          stall_cycles;
        logic        stall_at_done;
        logic        seen;
        applyStimulus(op, a, b, res, lat, stall_cycles, stall_at_done, seen);
        checkOutput({name, " valid_seen"}, {31'd0, seen}, 32'd1);
        checkOutput({name, " result"}, res, expected);
        checkOutput({name, " latency"}, lat, latency);
        checkOutput({name, " stall_cycles"}, stall_cycles, latency);
        checkOutput({name, " stall_in_done"}, {31'd0, stall_at_done}, 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int pulses;

        vecs[0]  = '{"DIVU 100/7",        OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"REMU 100/7",        OP_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"DIV -20/6",         OP_DIV,  32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{"REM -20/6",         OP_REM,  32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE,  33};
        vecs[4]  = '{"REM 20/-6",         OP_REM,  32'd20,         32'hFFFF_FFFA,  32'd2,          33};
        vecs[5]  = '{"DIV 20/-6",         OP_DIV,  32'd20,         32'hFFFF_FFFA,  32'hFFFF_FFFD,  33};
        vecs[6]  = '{"DIV -7/-2",         OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
        vecs[7]  = '{"REM -7/-2",         OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
        vecs[8]  = '{"DIV 5/0",           OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[9]  = '{"REMU 5/0",          OP_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[10] = '{"REM -5/0",          OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[11] = '{"DIVU 5/0",          OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[12] = '{"DIV ovf",           OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[13] = '{"REM ovf",           OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[14] = '{"DIVU ovf operands", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[15] = '{"REMU ovf operands", OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
        vecs[16] = '{"DIVU max/1",        OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[17] = '{"DIVU 7/9",          OP_DIVU, 32'd7,          32'd9,          32'd0,          33};
        vecs[18] = '{"REMU 7/9",          OP_REMU, 32'd7,          32'd9,          32'd7,          33};

        // Reset with a divider op already presented: stall must stay low.
        reset_i       = 1'b0;
        ex_flush_i    = 1'b0;
        id_valid_r    = 1'b1;
        id_alu_op_r   = OP_DIV;
        id_ra_value_r = 32'd1;
        id_rb_value_r = 32'd1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset res", div_res_w, 32'd0);
        checkOutput("reset valid", {31'd0, div_valid_w}, 32'd0);
        checkOutput("reset stall", {31'd0, ex_stall_div_w}, 32'd0);
        @(posedge clk_i);
        #1;
        id_valid_r = 1'b0;
        reset_i    = 1'b1;

        // Non-divider instructions must not stall or produce results.
        @(posedge clk_i);
        #1;
        id_valid_r  = 1'b1;
        id_alu_op_r = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("nondiv stall", {31'd0, ex_stall_div_w}, 32'd0);
            checkOutput("nondiv valid", {31'd0, div_valid_w}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        id_valid_r  = 1'b0;
        id_alu_op_r = OP_DIV;
        @(negedge clk_i);
        checkOutput("invalid div stall", {31'd0, ex_stall_div_w}, 32'd0);
        @(posedge clk_i);
        #1;

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < NUM_VECS; i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].expected, vecs[i].latency);
        end

        // Flush in cycle 10 of CALC: no pulse, then a clean full-length op.
        id_valid_r    = 1'b1;
        id_alu_op_r   = OP_DIVU;
        id_ra_value_r = 32'd100;
        id_rb_value_r = 32'd7;
        pulses        = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (div_valid_w) pulses++;
            @(posedge clk_i);
            #1;
        end
        ex_flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        ex_flush_i = 1'b0;
        id_valid_r = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (div_valid_w) pulses++;
        end
        checkOutput("flush no valid", pulses, 32'd0);
        @(posedge clk_i);
        #1;
        runOp("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Reset in cycle 15 of an op aborts it and clears all outputs.
        id_valid_r    = 1'b1;
        id_alu_op_r   = OP_DIV;
        id_ra_value_r = 32'd81;
        id_rb_value_r = 32'd9;
        repeat (15) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checkOutput("midop reset stall comb", {31'd0, ex_stall_div_w}, 32'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("midop reset res", div_res_w, 32'd0);
        checkOutput("midop reset valid", {31'd0, div_valid_w}, 32'd0);
        checkOutput("midop reset stall", {31'd0, ex_stall_div_w}, 32'd0);
        @(posedge clk_i);
        #1;
        id_valid_r = 1'b0;
        reset_i    = 1'b1;
        pulses     = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (div_valid_w) pulses++;
        end
        checkOutput("reset abort no valid", pulses, 32'd0);
        @(posedge clk_i);
        #1;

        // Back-to-back ops after reset: each gets exactly one DONE cycle.
        runOp("DIV 81/9", OP_DIV, 32'd81, 32'd9, 32'd9, 33);
        runOp("REM 81/10", OP_REM, 32'd81, 32'd10, 32'd1, 33);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (div_valid_w) pulses++;
        end
        checkOutput("no double issue", pulses, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
